// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 32 x 16-bit register file with full/upper-byte write,
//               increment, decrement and combinational full/upper-byte read.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        read,
    input  logic        readu,
    input  logic        write,
    input  logic        writeu,
    input  logic        inc,
    input  logic        dec,
    input  logic [5:0]  id,
    output logic [15:0] dout
);

    localparam int C_NUM_REGS = 32;

    logic [15:0] r_regs [C_NUM_REGS];
    logic [4:0]  w_addr;
    logic [15:0] w_sel;
    logic        w_unused_id5;

    // id[5] is reserved; R0..R31 alias across both halves of the id space
    assign w_addr       = id[4:0];
    assign w_unused_id5 = id[5];
    assign w_sel        = r_regs[w_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else if (write) begin
            r_regs[w_addr] <= din;
        end else if (writeu) begin
            r_regs[w_addr][15:8] <= din[7:0];
        end else if (inc) begin
            r_regs[w_addr] <= w_sel + 16'd1;
        end else if (dec) begin
            r_regs[w_addr] <= w_sel - 16'd1;
        end
    end

    // Reads see the stored value only; an update lands at the clock edge
    always_comb begin
        dout = 16'h0000;
        if (read) begin
            dout = w_sel;
        end else if (readu) begin
            dout = {8'h00, w_sel[15:8]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        read, readu, write, writeu, inc, dec;
    logic [5:0]  id;
    logic [15:0] dout;

    logic [15:0] model [32];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .read   (read),
        .readu  (readu),
        .write  (write),
        .writeu (writeu),
        .inc    (inc),
        .dec    (dec),
        .id     (id),
        .dout   (dout)
    );

    function automatic void model_update(input bit wr, input bit wu, input bit in,
                                         input bit de, input logic [5:0] a,
                                         input logic [15:0] d);
        int k;
        k = int'(a % 32);
        if (wr)      model[k] = d;
        else if (wu) model[k] = {d[7:0], model[k][7:0]};
        else if (in) model[k] = 16'((int'(model[k]) + 1) % 65536);
        else if (de) model[k] = 16'((int'(model[k]) + 65535) % 65536);
    endfunction

    function automatic logic [15:0] exp_dout(input bit r, input bit ru, input logic [5:0] a);
        if (r)  return model[a % 32];
        if (ru) return model[a % 32] / 256;
        return 16'h0000;
    endfunction

    task automatic idle();
        write = 0; writeu = 0; inc = 0; dec = 0; read = 0; readu = 0;
    endtask

    task automatic upd(input bit wr, input bit wu, input bit in, input bit de,
                       input logic [5:0] a, input logic [15:0] d);
        write = wr; writeu = wu; inc = in; dec = de; id = a; din = d;
        @(posedge clk); #1;
        model_update(wr, wu, in, de, a, d);
        write = 0; writeu = 0; inc = 0; dec = 0;
    endtask

    task automatic test_reset();
        idle(); din = 16'h0; id = 6'd0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 32; i++) model[i] = 16'h0000;
        for (int i = 0; i < 32; i++) begin
            read = 1; id = 6'(i); #1;
            checks++;
            if (dout !== 16'h0000) begin
                failures++;
                $display("FAIL reset_R%0d got=%h exp=0000", i, dout);
            end
        end
        idle();
    endtask

    task automatic test_directed();
        logic [15:0] exp;
        upd(1, 0, 0, 0, 6'd1, 16'h0F0F);
        read = 1; id = 6'd0; #1; checks++;
        if (dout !== 16'h0000) begin failures++; $display("FAIL rd_R0_init got=%h exp=0000", dout); end
        id = 6'd1; #1; checks++;
        if (dout !== 16'h0F0F) begin failures++; $display("FAIL rd_R1 got=%h exp=0F0F", dout); end
        read = 0;
        upd(1, 0, 0, 0, 6'd0, 16'h1F0F);
        read = 1; id = 6'd0; #1; checks++;
        if (dout !== 16'h1F0F) begin failures++; $display("FAIL wr_R0 got=%h exp=1F0F", dout); end
        read = 0;
        upd(0, 1, 0, 0, 6'd0, 16'h00F3);
        read = 1; id = 6'd0; #1; checks++;
        if (dout !== 16'hF30F) begin failures++; $display("FAIL writeu got=%h exp=F30F", dout); end
        read = 0; readu = 1; #1; checks++;
        if (dout !== 16'h00F3) begin failures++; $display("FAIL readu got=%h exp=00F3", dout); end
        readu = 0;
        upd(0, 0, 1, 0, 6'd0, 16'h0);
        read = 1; #1; checks++;
        if (dout !== 16'hF310) begin failures++; $display("FAIL inc got=%h exp=F310", dout); end
        read = 0;
        upd(0, 0, 0, 1, 6'd0, 16'h0);
        read = 1; #1; checks++;
        if (dout !== 16'hF30F) begin failures++; $display("FAIL dec got=%h exp=F30F", dout); end
        id = 6'd1; #1; checks++;
        if (dout !== 16'h0F0F) begin failures++; $display("FAIL R1_hold got=%h exp=0F0F", dout); end
        read = 0;
        exp = model[1];
        checks++;
        if (exp !== 16'h0F0F) begin failures++; $display("FAIL model_R1 got=%h exp=0F0F", exp); end
    endtask

    task automatic test_wrap();
        upd(1, 0, 0, 0, 6'd5, 16'hFFFF);
        upd(0, 0, 1, 0, 6'd5, 16'h0);
        read = 1; id = 6'd5; #1; checks++;
        if (dout !== 16'h0000) begin failures++; $display("FAIL inc_wrap got=%h exp=0000", dout); end
        read = 0;
        upd(0, 0, 0, 1, 6'd5, 16'h0);
        read = 1; #1; checks++;
        if (dout !== 16'hFFFF) begin failures++; $display("FAIL dec_wrap got=%h exp=FFFF", dout); end
        read = 0;
    endtask

    task automatic test_priority();
        upd(1, 1, 1, 1, 6'd6, 16'h1234);
        read = 1; id = 6'd6; #1; checks++;
        if (dout !== 16'h1234) begin failures++; $display("FAIL prio_write got=%h exp=1234", dout); end
        read = 0;
        upd(0, 1, 1, 1, 6'd6, 16'h00AB);
        read = 1; #1; checks++;
        if (dout !== 16'hAB34) begin failures++; $display("FAIL prio_writeu got=%h exp=AB34", dout); end
        read = 0;
        upd(0, 0, 1, 1, 6'd6, 16'h0);
        read = 1; #1; checks++;
        if (dout !== 16'hAB35) begin failures++; $display("FAIL prio_inc got=%h exp=AB35", dout); end
        read = 0;
        upd(1, 0, 0, 0, 6'd7, 16'hABCD);
        read = 1; readu = 1; id = 6'd7; #1; checks++;
        if (dout !== 16'hABCD) begin failures++; $display("FAIL rd_prio got=%h exp=ABCD", dout); end
        read = 0; readu = 0; #1; checks++;
        if (dout !== 16'h0000) begin failures++; $display("FAIL rd_none got=%h exp=0000", dout); end
    endtask

    task automatic test_alias();
        upd(1, 0, 0, 0, 6'b100011, 16'h3C3C);
        read = 1; id = 6'd3; #1; checks++;
        if (dout !== 16'h3C3C) begin failures++; $display("FAIL id5_alias got=%h exp=3C3C", dout); end
        read = 0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] old;
        upd(1, 0, 0, 0, 6'd9, 16'h00FE);
        read = 1; id = 6'd9;
        for (int i = 0; i < 4; i++) begin
            old = model[9];
            inc = 1; #1; checks++;
            if (dout !== old) begin failures++; $display("FAIL no_bypass_%0d got=%h exp=%h", i, dout, old); end
            @(posedge clk); #1;
            model_update(0, 0, 1, 0, 6'd9, 16'h0);
            checks++;
            if (dout !== model[9]) begin failures++; $display("FAIL post_edge_%0d got=%h exp=%h", i, dout, model[9]); end
        end
        idle();
    endtask

    task automatic test_reset_with_write();
        rst_n = 0; write = 1; inc = 1; id = 6'd3; din = 16'h5555;
        @(posedge clk); #1;
        rst_n = 1; idle();
        for (int i = 0; i < 32; i++) model[i] = 16'h0000;
        for (int i = 0; i < 32; i++) begin
            read = 1; id = 6'(i); #1; checks++;
            if (dout !== 16'h0000) begin
                failures++;
                $display("FAIL rst_discard_R%0d got=%h exp=0000", i, dout);
            end
        end
        idle();
    endtask

    task automatic test_random();
        bit wr, wu, in, de;
        logic [15:0] exp;
        for (int n = 0; n < 400; n++) begin
            wr = ($urandom_range(0, 9) < 3);
            wu = ($urandom_range(0, 9) < 3);
            in = ($urandom_range(0, 9) < 3);
            de = ($urandom_range(0, 9) < 3);
            write = wr; writeu = wu; inc = in; dec = de;
            read  = 1'($urandom_range(0, 1));
            readu = 1'($urandom_range(0, 1));
            id  = 6'($urandom_range(0, 63));
            din = 16'($urandom);
            if (n % 4 == 0) din = {8'h00, 8'hFF};
            #1;
            exp = exp_dout(read, readu, id);
            checks++;
            if (dout !== exp) begin failures++; $display("FAIL rand_%0d got=%h exp=%h", n, dout, exp); end
            @(posedge clk); #1;
            model_update(wr, wu, in, de, id, din);
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            read = 1; id = 6'(i); #1; checks++;
            if (dout !== model[i]) begin
                failures++;
                $display("FAIL rand_final_R%0d got=%h exp=%h", i, dout, model[i]);
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 0; din = 16'h0; id = 6'd0;
        idle();
        test_reset();
        test_directed();
        test_wrap();
        test_priority();
        test_alias();
        test_back_to_back();
        test_reset_with_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-004 din  input  16  write data.
REQ-005 read  input  1  when high, drive selected register's full 16-bit value onto dout.
REQ-006 readu  input  1  when high, drive selected register's upper byte, zero-extended, onto dout.
REQ-007 write  input  1  when high at clk edge, load din into selected register.
REQ-008 writeu  input  1  when high at clk edge, load din[7:0] into selected register's upper byte.
REQ-009 inc  input  1  when high at clk edge, increment selected register by 1.
REQ-010 dec  input  1  when high at clk edge, decrement selected register by 1.
REQ-011 id  input  6  register select; id[4:0] addresses R0..R31; id[5] reserved and ignored.
REQ-012 dout  output  16  read data, combinational.

Function
REQ-013 Storage SHALL be 32 general registers R0..R31, 16 bits each; R0 is an ordinary read/write register, not hardwired.
REQ-014 write: R[id] <= din[15:0] on the rising edge.
REQ-015 writeu: R[id][15:8] <= din[7:0]; R[id][7:0] unchanged.
REQ-016 inc: R[id] <= R[id] + 1, modulo 2^16 (0xFFFF -> 0x0000).
REQ-017 dec: R[id] <= R[id] - 1, modulo 2^16 (0x0000 -> 0xFFFF).
REQ-018 At most one update per edge; priority when several update strobes are high: write > writeu > inc > dec; lower-priority strobes are ignored that cycle.
REQ-019 Only the register addressed by id SHALL change; all other registers hold.
REQ-020 No update strobe high: all registers hold.
REQ-021 dout SHALL be combinational from read, readu, id and register contents, with no clock latency.
REQ-022 read high: dout = R[id]; readu high and read low: dout = {8'h00, R[id][15:8]}; both low: dout = 16'h0000.
REQ-023 read and readu both high: read takes priority.
REQ-024 Read during an update to the same register SHALL return the pre-edge value until the edge, then the new value (no write-through bypass).
REQ-025 Read and update strobes are independent and may be asserted in the same cycle.

Reset
REQ-026 With rst_n low at a rising clk edge, all 32 registers SHALL clear to 16'h0000; reset overrides all update strobes.
REQ-027 dout is not reset directly; after reset it reflects REQ-022 on cleared registers (0x0000).
REQ-028 Reset asserted in the same cycle as write/writeu/inc/dec SHALL discard the update.

Verification
REQ-029 Reset, then write R1 = 0x0F0F; read id=0 -> dout 0x0000; read id=1 -> dout 0x0F0F.
REQ-030 Write R0 = 0x1F0F, read -> 0x1F0F; writeu din = 0x00F3, read -> 0xF30F; readu -> 0x00F3.
REQ-031 R0 = 0xF30F: inc, read -> 0xF310; dec, read -> 0xF30F; R1 still 0x0F0F.
REQ-032 Wrap: write R5 = 0xFFFF, inc -> 0x0000; dec -> 0xFFFF.
REQ-033 Priority: write din = 0x1234 with inc and dec also high -> 0x1234; read and readu both high on 0xABCD -> dout 0xABCD; both low -> 0x0000.
REQ-034 id = 6'b100011 addresses R3 (id[5] ignored); rst_n low together with write -> all registers 0x0000, write discarded.
